// File: rtl/matmul_output_collector.sv
// Output-collection stage for the systolic matmul: samples staggered per-column
// results from the array and proxy bus, accumulates them, and writes rows to memory.

module matmul_oc_sampler #(
    parameter int ROWS        = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int RI          = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          active,
    input  logic          stall,
    input  logic          valid,
    output logic          sample,
    output logic          drop,
    output logic [RI-1:0] row
);
    localparam int PW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = $clog2(ROWS + 1);

    logic [PW-1:0] phase;
    logic [RW-1:0] row_cnt;
    logic          hit;
    logic          full;

    assign hit    = active && valid && !stall && (phase == '0);
    assign full   = (row_cnt >= RW'(ROWS));
    assign sample = hit && !full;
    assign drop   = hit && full;
    assign row    = row_cnt[RI-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr || !active || !valid)
            phase <= '0;
        else if (!stall)
            phase <= (phase == PW'(HOLD_CYCLES - 1)) ? '0 : phase + 1'b1;
    end

    // Counter parks at ROWS so every further sample is reported as a drop.
    always_ff @(posedge clk) begin
        if (rst || clr)
            row_cnt <= '0;
        else if (sample)
            row_cnt <= row_cnt + 1'b1;
    end
endmodule

module matmul_output_collector #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int SATURATE    = 1,
    parameter int ADDR_WIDTH  = 32,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_INCR   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear_acc,
    input  logic                      stall,
    input  logic [COLS*WORD_SIZE-1:0] sa_data,
    input  logic [COLS-1:0]           sa_valid,
    input  logic [COLS*WORD_SIZE-1:0] px_data,
    input  logic [COLS-1:0]           px_valid,
    input  logic                      fsm_done,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [COLS*WORD_SIZE-1:0] mem_data,
    output logic                      mem_wr_en,
    input  logic                      mem_ack
);
    localparam int W  = WORD_SIZE;
    localparam int RI = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, WAIT_ACK, FINISH} state_t;
    state_t state, state_nx;

    logic [ROWS-1:0][COLS-1:0][W-1:0] sa_acc, px_acc;
    logic [COLS-1:0][RI-1:0]          sa_row, px_row;
    logic [COLS-1:0]                  sa_smp, px_smp, sa_drop, px_drop;
    logic [COLS-1:0][W:0]             sa_sum, px_sum, wr_sum;
    logic [COLS*W-1:0]                row_data;
    logic                             smp_clamp, row_clamp;
    logic [RI-1:0]                    wr_row;
    logic                             ack_early;
    logic                             arm;
    logic                             collecting;

    assign arm        = (state == IDLE) && start;
    assign collecting = (state == COLLECT);

    // Returns {clamped, result}; clamping only when SATURATE is set.
    function automatic logic [W:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (SATURATE != 0 && (s[W] != s[W-1]))
            return s[W] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
        return {1'b0, s[W-1:0]};
    endfunction

    for (genvar c = 0; c < COLS; c++) begin : g_col
        matmul_oc_sampler #(.ROWS(ROWS), .HOLD_CYCLES(HOLD_CYCLES), .RI(RI)) u_sa (
            .clk(clk), .rst(rst), .clr(arm), .active(collecting), .stall(stall),
            .valid(sa_valid[c]), .sample(sa_smp[c]), .drop(sa_drop[c]), .row(sa_row[c])
        );
        matmul_oc_sampler #(.ROWS(ROWS), .HOLD_CYCLES(HOLD_CYCLES), .RI(RI)) u_px (
            .clk(clk), .rst(rst), .clr(arm), .active(collecting), .stall(stall),
            .valid(px_valid[c]), .sample(px_smp[c]), .drop(px_drop[c]), .row(px_row[c])
        );
    end

    always_comb begin
        smp_clamp = 1'b0;
        row_clamp = 1'b0;
        row_data  = '0;
        for (int c = 0; c < COLS; c++) begin
            sa_sum[c] = add_sat(sa_acc[sa_row[c]][c], sa_data[c*W +: W]);
            px_sum[c] = add_sat(px_acc[px_row[c]][c], px_data[c*W +: W]);
            wr_sum[c] = add_sat(sa_acc[wr_row][c], px_acc[wr_row][c]);
            smp_clamp = smp_clamp | (sa_smp[c] & sa_sum[c][W]) | (px_smp[c] & px_sum[c][W]);
            row_clamp = row_clamp | wr_sum[c][W];
            row_data[c*W +: W] = wr_sum[c][W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_acc <= '0;
            px_acc <= '0;
        end else if (arm && clear_acc) begin
            sa_acc <= '0;
            px_acc <= '0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (sa_smp[c]) sa_acc[sa_row[c]][c] <= sa_sum[c][W-1:0];
                if (px_smp[c]) px_acc[px_row[c]][c] <= px_sum[c][W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || arm)
            overflow <= 1'b0;
        else if ((collecting && ((|sa_drop) || (|px_drop) || smp_clamp)) ||
                 (state == WRITE && row_clamp))
            overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_row    <= '0;
            ack_early <= 1'b0;
        end else begin
            state     <= state_nx;
            ack_early <= (state == WRITE) && mem_ack;
            if (arm)
                wr_row <= '0;
            else if (state == WAIT_ACK && (mem_ack || ack_early) && wr_row != RI'(ROWS - 1))
                wr_row <= wr_row + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = COLLECT;
            COLLECT:  if (fsm_done) state_nx = WRITE;
            WRITE:    state_nx = WAIT_ACK;
            WAIT_ACK: if (mem_ack || ack_early)
                          state_nx = (wr_row == RI'(ROWS - 1)) ? FINISH : WRITE;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Accumulators are frozen outside COLLECT, so the row outputs stay stable until ack.
    logic writing;
    assign writing   = (state == WRITE) || (state == WAIT_ACK);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign mem_wr_en = (state == WRITE) || (state == WAIT_ACK && !ack_early);
    assign mem_data  = writing ? row_data : '0;
    assign mem_addr  = writing ? ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(wr_row) * ADDR_WIDTH'(ADDR_INCR)
                               : '0;
endmodule

// File: tb/tb_matmul_output_collector.sv
// Directed bench for matmul_output_collector: saturating and wrapping instances share stimulus.

module tb_matmul_output_collector;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int W  = 16;
    localparam int AW = 32;

    logic clk = 0;
    logic rst, start, clear_acc, stall, fsm_done, mem_ack;
    logic [C*W-1:0] sa_data, px_data;
    logic [C-1:0]   sa_valid, px_valid;
    logic busy, done, overflow, mem_wr_en;
    logic [AW-1:0]  mem_addr;
    logic [C*W-1:0] mem_data;
    logic busy1, done1, overflow1, mem_wr_en1;
    logic [AW-1:0]  mem_addr1;
    logic [C*W-1:0] mem_data1;

    always #5 clk = ~clk;

    matmul_output_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .HOLD_CYCLES(2), .SATURATE(1),
        .ADDR_WIDTH(AW), .BASE_ADDR(0), .ADDR_INCR(4)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .stall(stall),
        .sa_data(sa_data), .sa_valid(sa_valid), .px_data(px_data), .px_valid(px_valid),
        .fsm_done(fsm_done), .busy(busy), .done(done), .overflow(overflow),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en), .mem_ack(mem_ack));

    matmul_output_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .HOLD_CYCLES(2), .SATURATE(0),
        .ADDR_WIDTH(AW), .BASE_ADDR(0), .ADDR_INCR(4)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .stall(stall),
        .sa_data(sa_data), .sa_valid(sa_valid), .px_data(px_data), .px_valid(px_valid),
        .fsm_done(fsm_done), .busy(busy1), .done(done1), .overflow(overflow1),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_wr_en(mem_wr_en1), .mem_ack(mem_ack));

    int tests = 0;
    int fails = 0;

    logic [W-1:0]   sa_m [R][C];
    logic [W-1:0]   px_m [R][C];
    logic [C-1:0]   px_mask;
    logic [AW-1:0]  wr_addr  [8];
    logic [C*W-1:0] wr_data  [8];
    logic [C*W-1:0] wr_data1 [8];
    int nw, done_at, first_wr;

    task automatic load_basic();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                sa_m[r][c] = W'(10*r + c);
                px_m[r][c] = '0;
            end
        px_mask = '0;
    endtask

    task automatic arm(input logic clr);
        @(negedge clk);
        start = 1; clear_acc = clr;
        @(negedge clk);
        start = 0; clear_acc = 0;
    endtask

    // Column c presents row r on cycles c+2r and c+2r+1.
    task automatic drive_tile();
        for (int t = 0; t < 2*R + C - 1; t++) begin
            for (int c = 0; c < C; c++) begin
                int k;
                k = t - c;
                if (k >= 0 && k < 2*R) begin
                    sa_valid[c] = 1'b1;
                    sa_data[c*W +: W] = sa_m[k/2][c];
                    px_valid[c] = px_mask[c];
                    px_data[c*W +: W] = px_m[k/2][c];
                end else begin
                    sa_valid[c] = 1'b0;
                    sa_data[c*W +: W] = '0;
                    px_valid[c] = 1'b0;
                    px_data[c*W +: W] = '0;
                end
            end
            @(negedge clk);
        end
        sa_valid = '0; px_valid = '0; sa_data = '0; px_data = '0;
    endtask

    task automatic finish_collect();
        fsm_done = 1;
        nw = 0; done_at = -1; first_wr = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            @(negedge clk);
            fsm_done = 0;
            if (mem_wr_en) begin
                if (first_wr < 0) first_wr = i;
                if (nw < 8) begin
                    wr_addr[nw] = mem_addr;
                    wr_data[nw] = mem_data;
                    wr_data1[nw] = mem_data1;
                end
                nw++;
            end
            if (done) done_at = i;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        tests++; if (mem_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", mem_data); end
    endtask

    task automatic test_basic();
        logic [C*W-1:0] exp;
        load_basic();
        arm(1);
        drive_tile();
        finish_collect();
        tests++; if (nw !== 4) begin fails++; $display("FAIL basic_nwrites got %0d want 4", nw); end
        tests++; if (first_wr !== 1) begin fails++; $display("FAIL basic_first_wr got %0d want 1", first_wr); end
        tests++; if (done_at !== 9) begin fails++; $display("FAIL basic_done_latency got %0d want 9", done_at); end
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) exp[c*W +: W] = W'(10*r + c);
            tests++; if (wr_addr[r] !== AW'(4*r)) begin fails++; $display("FAIL basic_addr row %0d got %h want %h", r, wr_addr[r], 4*r); end
            tests++; if (wr_data[r] !== exp) begin fails++; $display("FAIL basic_data row %0d got %h want %h", r, wr_data[r], exp); end
        end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow got %b want 0", overflow); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_px();
        logic [C*W-1:0] exp;
        load_basic();
        for (int r = 0; r < R; r++) px_m[r][1] = W'(5);
        px_mask = 4'b0010;
        arm(1);
        drive_tile();
        finish_collect();
        tests++; if (nw !== 4) begin fails++; $display("FAIL px_nwrites got %0d want 4", nw); end
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) exp[c*W +: W] = W'(10*r + c + ((c == 1) ? 5 : 0));
            tests++; if (wr_data[r] !== exp) begin fails++; $display("FAIL px_data row %0d got %h want %h", r, wr_data[r], exp); end
        end
    endtask

    task automatic test_tiles();
        logic [C*W-1:0] exp;
        load_basic();
        arm(1); drive_tile(); finish_collect();
        arm(0); drive_tile(); finish_collect();
        tests++; if (nw !== 4) begin fails++; $display("FAIL tiles_nwrites got %0d want 4", nw); end
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) exp[c*W +: W] = W'(2 * (10*r + c));
            tests++; if (wr_data[r] !== exp) begin fails++; $display("FAIL tiles_data row %0d got %h want %h", r, wr_data[r], exp); end
        end
    endtask

    task automatic test_saturate();
        load_basic();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) sa_m[r][c] = '0;
        sa_m[0][0] = 16'h7FF0;
        px_m[0][0] = 16'h0020;
        px_mask = 4'b0001;
        arm(1); drive_tile(); finish_collect();
        tests++; if (wr_data[0][W-1:0] !== 16'h7FFF) begin fails++; $display("FAIL sat_word got %h want 7fff", wr_data[0][W-1:0]); end
        tests++; if (wr_data1[0][W-1:0] !== 16'h8010) begin fails++; $display("FAIL wrap_word got %h want 8010", wr_data1[0][W-1:0]); end
        tests++; if (wr_data[1] !== '0) begin fails++; $display("FAIL sat_row1 got %h want 0", wr_data[1]); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL sat_overflow got %b want 1", overflow); end
        tests++; if (overflow1 !== 1'b0) begin fails++; $display("FAIL wrap_overflow got %b want 0", overflow1); end
    endtask

    task automatic test_drop_stall();
        int dv [12] = '{1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 5, 5};
        bit st [12] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic [C*W-1:0] exp;
        arm(1);
        for (int t = 0; t < 12; t++) begin
            sa_valid = 4'b0001;
            sa_data[W-1:0] = W'(dv[t]);
            stall = st[t];
            @(negedge clk);
        end
        sa_valid = '0; sa_data = '0; stall = 0;
        finish_collect();
        tests++; if (nw !== 4) begin fails++; $display("FAIL drop_nwrites got %0d want 4", nw); end
        for (int r = 0; r < R; r++) begin
            exp = '0;
            exp[W-1:0] = W'(r + 1);
            tests++; if (wr_data[r] !== exp) begin fails++; $display("FAIL drop_data row %0d got %h want %h", r, wr_data[r], exp); end
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL drop_overflow got %b want 1", overflow); end
    endtask

    task automatic test_ack_reset();
        logic [C*W-1:0] exp;
        int n;
        bit saw_done, saw_wr;
        load_basic();
        mem_ack = 0;
        arm(1); drive_tile();
        fsm_done = 1;
        @(negedge clk);
        fsm_done = 0;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!mem_wr_en && n < 10) begin @(negedge clk); n++; end
            tests++; if (n >= 10) begin fails++; $display("FAIL ack_wait_timeout row %0d got no write want write", r); end
            for (int c = 0; c < C; c++) exp[c*W +: W] = W'(10*r + c);
            for (int k = 0; k < ((r < 2) ? 3 : 2); k++) begin
                tests++;
                if (mem_wr_en !== 1'b1 || mem_addr !== AW'(4*r) || mem_data !== exp) begin
                    fails++;
                    $display("FAIL ack_hold row %0d cyc %0d got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                             r, k, mem_wr_en, mem_addr, mem_data, 4*r, exp);
                end
                if (r < 2 && k == 2) mem_ack = 1;
                @(negedge clk);
            end
            mem_ack = 0;
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL rst_abort_wr_en got %b want 0", mem_wr_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_abort_busy got %b want 0", busy); end
        saw_done = 0; saw_wr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (mem_wr_en) saw_wr = 1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rst_abort_done got 1 want 0"); end
        tests++; if (saw_wr !== 1'b0) begin fails++; $display("FAIL rst_abort_late_wr got 1 want 0"); end
        mem_ack = 1;
    endtask

    initial begin
        rst = 1; start = 0; clear_acc = 0; stall = 0; fsm_done = 0; mem_ack = 1;
        sa_data = '0; px_data = '0; sa_valid = '0; px_valid = '0;
        test_reset();
        test_basic();
        test_px();
        test_tiles();
        test_saturate();
        test_drop_stall();
        test_ack_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matmul_output_collector.md
Name: matmul_output_collector

Overview:
Parametrised output-collection stage for the weight/input-stationary systolic matmul flow. It captures staggered per-column outputs from the systolic array and from the proxy (spare) PE bus into two on-chip ROWS x COLS accumulators. It sums them with optional saturation and writes the result matrix row by row to memory over a ready/ack handshake. It replaces fixed-latency memory timing with an ack handshake and adds multi-tile accumulation, configurable output hold, and overflow reporting.

Parameters:
ROWS, 4, output matrix rows (>=1)
COLS, 4, output matrix columns; also memory row width in words
WORD_SIZE, 16, signed element width
HOLD_CYCLES, 2, cycles each valid output is held by the source (1..4)
SATURATE, 1, 1 = saturating signed add; 0 = wrap-around add
ADDR_WIDTH, 32, memory address width
BASE_ADDR, 0, address of output row 0
ADDR_INCR, 4, address step per row

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  arm collection (IDLE only)
clear_acc  in  1  sampled with start; 1 = zero both accumulators, 0 = keep (tile accumulation)
stall  in  1  freeze sampling
sa_data  in  COLS*WORD_SIZE  systolic column outputs, column c at [c*WORD_SIZE +: WORD_SIZE]
sa_valid  in  COLS  per-column valid
px_data  in  COLS*WORD_SIZE  proxy outputs, same packing
px_valid  in  COLS  per-column proxy valid
fsm_done  in  1  matmul FSM finished
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after last row acked
overflow  out  1  sticky: saturation occurred or a row index exceeded ROWS-1
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  COLS*WORD_SIZE  row data
mem_wr_en  out  1  write request
mem_ack  in  1  memory accepted current write

Behaviour:
- Reset: state IDLE. busy=0, done=0, overflow=0, mem_wr_en=0, mem_addr=0, mem_data=0. Accumulators, row counters and phase counters are zeroed. Reset mid-operation aborts any write immediately with no further mem_wr_en.
- States: IDLE -> COLLECT -> WRITE -> WAIT_ACK -> (WRITE | FINISH) -> IDLE.
- IDLE: start=1 -> COLLECT next cycle. Row and phase counters are zeroed and overflow is cleared. If clear_acc=1, both accumulators are zeroed. fsm_done is ignored in IDLE.
- COLLECT, sampling per column c, independently for the sa and px paths:
  - A phase counter counts 0..HOLD_CYCLES-1 while valid[c]=1 and stall=0.
  - A sample occurs on cycles where phase=0. Phase advances mod HOLD_CYCLES.
  - valid[c]=0 forces phase to 0. stall=1 freezes phase, and no sample occurs.
- On a sample: acc[row_cnt[c]][c] <= acc[row_cnt[c]][c] + data_c, then row_cnt[c]++.
  - If row_cnt[c] >= ROWS, the sample is dropped, overflow is set, and the counter saturates at ROWS.
- Add rule: sign-extend to WORD_SIZE+1 bits.
  - SATURATE=1: clamp to [-2^(W-1), 2^(W-1)-1] and set overflow when a clamp occurs.
  - SATURATE=0: keep the low W bits.
- COLLECT exit: fsm_done=1 -> WRITE. Samples presented in that same cycle are still taken.
- WRITE (row r, r starts at 0):
  - mem_wr_en=1, mem_addr=BASE_ADDR+r*ADDR_INCR.
  - mem_data word c = sat/wrap(sa_acc[r][c] + px_acc[r][c]) under the same add rule. Saturation here sets overflow.
  - Next state is WAIT_ACK.
- WAIT_ACK:
  - mem_wr_en, mem_addr and mem_data are held stable until mem_ack=1.
  - On ack: mem_wr_en=0. If r=ROWS-1 -> FINISH; else r++ -> WRITE.
  - A write whose ack arrives in the same cycle as mem_wr_en first rises is legal: WAIT_ACK lasts 1 cycle.
- FINISH: done=1 for one cycle -> IDLE. Accumulators are retained.
- start outside IDLE is ignored. stall has no effect on WRITE/WAIT_ACK.
- Latency: the first mem_wr_en is asserted 1 cycle after fsm_done. With ack on the first possible cycle, a row takes 2 cycles, so done is asserted 2*ROWS+1 cycles after fsm_done.

Test Plan:
- Defaults, clear_acc=1. Drive column c's row r output = 10*r+c, each held 2 cycles and staggered 1 cycle per column; px_valid=0; fsm_done; ack immediately -> four writes at addresses 0,4,8,12 with row r data {10r+3,10r+2,10r+1,10r}, done asserted 9 cycles after fsm_done, overflow=0.
- Same stimulus, px col 1 drives 5 for every row -> every row word 1 is 10r+1+5.
- Two tiles: tile A with clear_acc=1, then tile B with clear_acc=0 using identical data -> memory rows are double the first-scenario values.
- SATURATE=1: sa=0x7FF0 and px=0x0020 in one cell -> written word 0x7FFF, overflow=1. SATURATE=0 with the same inputs -> 0x8010.
- Five valid samples on column 0 (ROWS=4) -> fifth sample dropped, overflow=1, rows 0-3 unaffected. stall asserted during a hold window -> no duplicate or missed sample.
- mem_ack delayed 3 cycles per row, with rst pulsed during row 2 -> addr/data stable while waiting; after rst, mem_wr_en=0, busy=0, no done.
